// File: rtl/rram_pkg.sv
// Shared types and constants for the RRAM access controller.
// Op encodings, FSM states, address/length widths, default timings.
package rram_pkg;

  localparam int ADDR_W = 12;
  localparam int LEN_W  = 8;
  localparam int TMR_W  = 8;

  localparam int T_SETUP_DEF   = 2;
  localparam int T_WPULSE_DEF  = 4;
  localparam int T_RPULSE_DEF  = 2;
  localparam int T_RECOV_DEF   = 1;
  localparam int MAX_RETRY_DEF = 3;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_SET   = 2'b01,
    OP_RESET = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SETUP,
    ST_WPULSE,
    ST_RECOV,
    ST_SENSE,
    ST_EVAL,
    ST_ADV,
    ST_DONE
  } state_e;

  // A phase of N cycles loads N-1; expiry marks its last cycle.
  function automatic logic [TMR_W-1:0] tmr_val(
    input int cycles
  );
    return TMR_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/rram_phase_timer.sv
// Loadable down-counter timing one controller phase.
// Ports: clk, rst (sync, high), load/value, expired (phase's last cycle).
module rram_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/rram_access_ctrl.sv
// RRAM cell access sequencer: read, write with verify and retry.
// Ports: cmd_* handshake, sense_in, dec_* decoder, wl_*/sa_en array
// drives, rd_valid/rd_data, busy/done, sticky err and fail_addr.
module rram_access_ctrl
  import rram_pkg::*;
#(
  parameter int T_SETUP   = T_SETUP_DEF,
  parameter int T_WPULSE  = T_WPULSE_DEF,
  parameter int T_RPULSE  = T_RPULSE_DEF,
  parameter int T_RECOV   = T_RECOV_DEF,
  parameter int MAX_RETRY = MAX_RETRY_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              sense_in,
  output logic              dec_ale,
  output logic              dec_en,
  output logic [ADDR_W-1:0] dec_addr,
  output logic              wl_set,
  output logic              wl_reset,
  output logic              sa_en,
  output logic              rd_valid,
  output logic              rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] fail_addr
);

  localparam logic [LEN_W-1:0] RETRY_MAX = LEN_W'(MAX_RETRY);

  state_e            state;
  state_e            state_nx;
  op_e               op;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remain;
  logic [LEN_W-1:0]  retry;
  logic              sbit;
  logic              err_q;
  logic [ADDR_W-1:0] fail_q;

  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_cnt;
  logic              tmr_exp;

  logic accept;
  logic rsvd_in;
  logic is_write;
  logic pass;
  logic can_retry;
  logic last;

  assign accept    = cmd_valid && (state == ST_IDLE) && !rst;
  assign rsvd_in   = (op_e'(cmd_op) == OP_RSVD);
  assign is_write  = (op == OP_SET) || (op == OP_RESET);
  assign pass      = (sbit == (op == OP_SET));
  assign can_retry = (retry < RETRY_MAX);
  assign last      = (remain == '0);

  rram_phase_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .value  (tmr_cnt),
    .expired(tmr_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    tmr_load = 1'b0;
    tmr_cnt  = '0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx = rsvd_in ? ST_DONE : ST_LATCH;
        end
      end
      ST_LATCH: begin
        state_nx = ST_SETUP;
        tmr_load = 1'b1;
        tmr_cnt  = tmr_val(T_SETUP);
      end
      ST_SETUP: begin
        if (tmr_exp) begin
          tmr_load = 1'b1;
          if (op == OP_READ) begin
            state_nx = ST_SENSE;
            tmr_cnt  = tmr_val(T_RPULSE);
          end else begin
            state_nx = ST_WPULSE;
            tmr_cnt  = tmr_val(T_WPULSE);
          end
        end
      end
      ST_WPULSE: begin
        if (tmr_exp) begin
          state_nx = ST_RECOV;
          tmr_load = 1'b1;
          tmr_cnt  = tmr_val(T_RECOV);
        end
      end
      ST_RECOV: begin
        if (tmr_exp) begin
          state_nx = ST_SENSE;
          tmr_load = 1'b1;
          tmr_cnt  = tmr_val(T_RPULSE);
        end
      end
      ST_SENSE: begin
        if (tmr_exp) begin
          state_nx = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (is_write && !pass && can_retry) begin
          // Retry pulses skip setup: address is still driven.
          state_nx = ST_WPULSE;
          tmr_load = 1'b1;
          tmr_cnt  = tmr_val(T_WPULSE);
        end else if (last) begin
          state_nx = ST_DONE;
        end else begin
          state_nx = ST_ADV;
        end
      end
      ST_ADV: begin
        state_nx = ST_SETUP;
        tmr_load = 1'b1;
        tmr_cnt  = tmr_val(T_SETUP);
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op     <= OP_READ;
      addr   <= '0;
      remain <= '0;
      retry  <= '0;
      sbit   <= 1'b0;
      err_q  <= 1'b0;
      fail_q <= '0;
    end else begin
      if (accept) begin
        op     <= op_e'(cmd_op);
        addr   <= cmd_addr;
        remain <= cmd_len;
        retry  <= '0;
        err_q  <= rsvd_in;
        fail_q <= rsvd_in ? cmd_addr : '0;
      end
      if ((state == ST_SENSE) && tmr_exp) begin
        sbit <= sense_in;
      end
      if ((state == ST_EVAL) && is_write && !pass) begin
        if (can_retry) begin
          retry <= retry + 1'b1;
        end else begin
          err_q <= 1'b1;
          if (!err_q) begin
            fail_q <= addr;
          end
        end
      end
      if (state == ST_ADV) begin
        addr   <= addr + 1'b1;
        remain <= remain - 1'b1;
        retry  <= '0;
      end
    end
  end

  // Outputs are forced low while rst is high, even mid-phase.
  always_comb begin
    cmd_ready = 1'b0;
    dec_ale   = 1'b0;
    dec_en    = 1'b0;
    dec_addr  = '0;
    wl_set    = 1'b0;
    wl_reset  = 1'b0;
    sa_en     = 1'b0;
    rd_valid  = 1'b0;
    rd_data   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    fail_addr = '0;
    if (!rst) begin
      cmd_ready = (state == ST_IDLE);
      dec_ale   = (state == ST_LATCH);
      dec_en    = (state == ST_ADV);
      dec_addr  = addr;
      wl_set    = (state == ST_WPULSE) && (op == OP_SET);
      wl_reset  = (state == ST_WPULSE) && (op == OP_RESET);
      sa_en     = (state == ST_SENSE);
      rd_valid  = (state == ST_EVAL) && (op == OP_READ);
      rd_data   = (state == ST_EVAL) && (op == OP_READ) && sbit;
      busy      = (state != ST_IDLE);
      done      = (state == ST_DONE);
      err       = err_q;
      fail_addr = fail_q;
    end
  end

endmodule

// File: doc/rram_access_ctrl.md
RRAM_ACCESS_CTRL -- requirements
Module: rram_access_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  T_SETUP, 2, cycles between address valid and first pulse.
  T_WPULSE, 4, SET/RESET pulse width in cycles.
  T_RPULSE, 2, sense-amp enable width in cycles.
  T_RECOV, 1, idle cycles after a write pulse.
  MAX_RETRY, 3, extra write pulses allowed after a failed verify.
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  in  1  sole clock, rising edge.
  rst  in  1  synchronous reset, active-high.
  cmd_valid  in  1  command request.
  cmd_ready  out  1  controller can accept a command.
  cmd_op  in  2  00 READ, 01 SET (write 1), 10 RESET (write 0), 11 reserved.
  cmd_addr  in  12  start address {block[1:0], row[4:0], column[4:0]}.
  cmd_len  in  8  cell count minus 1 (1..256 cells).
  sense_in  in  1  sense-amp output from array.
  dec_ale  out  1  decoder address-latch enable.
  dec_en  out  1  decoder count enable (+1 per cycle high).
  dec_addr  out  12  decoder din.
  wl_set  out  1  SET pulse.
  wl_reset  out  1  RESET pulse.
  sa_en  out  1  sense-amp enable.
  rd_valid  out  1  rd_data valid, one-cycle strobe.
  rd_data  out  1  sensed bit.
  busy  out  1  command in progress.
  done  out  1  one-cycle end-of-command strobe.
  err  out  1  sticky verify failure / illegal op.
  fail_addr  out  12  address of first failing cell.

Function
REQ-003 Handshake: command accepted on a cycle with cmd_valid=1 and cmd_ready=1; cmd_ready=1 only in IDLE; op, addr, len captured on acceptance.
REQ-004 States: IDLE, LATCH, SETUP, WPULSE, RECOV, SENSE, EVAL, ADV, DONE.
REQ-005 IDLE->LATCH on acceptance; LATCH lasts 1 cycle with dec_ale=1, dec_addr=captured addr; LATCH->SETUP.
REQ-006 SETUP lasts T_SETUP cycles; then WPULSE for SET/RESET, SENSE for READ.
REQ-007 WPULSE: wl_set (SET) or wl_reset (RESET) high exactly T_WPULSE cycles; then RECOV for T_RECOV cycles; then SENSE (verify read).
REQ-008 SENSE: sa_en high exactly T_RPULSE cycles; sense_in sampled on last sa_en cycle; then EVAL (1 cycle).
REQ-009 EVAL, READ: rd_valid=1, rd_data=sampled bit.
REQ-010 EVAL, write: pass if sampled bit equals target bit; fail with retry count < MAX_RETRY -> increment count, go to WPULSE (no re-setup); fail at MAX_RETRY -> set err, load fail_addr if err was clear, proceed as pass.
REQ-011 Retry count clears per cell.
REQ-012 After EVAL: last cell -> DONE; else ADV: dec_en=1 for 1 cycle, internal address +1, then SETUP (no relatch).
REQ-013 DONE: done=1 for 1 cycle, then IDLE; busy=1 from LATCH through DONE.
REQ-014 Address arithmetic modulo 4096: 0xFFF+1 = 0x000; dec_addr tracks the current cell address.
REQ-015 Op 11: accepted, no array activity, err=1, fail_addr=cmd_addr, DONE on next cycle.
REQ-016 err and fail_addr clear on acceptance of the next command.
REQ-017 Invariants: wl_set and wl_reset never high together; neither overlaps sa_en; dec_ale and dec_en never high together.
REQ-018 Default latencies (acceptance = cycle 0):
  1-cell READ: ale at 1, sa_en at 4-5, rd_valid at 6, done at 7.
  1-cell passing write: pulse at 4-7, sa_en at 9-10, done at 12.

Reset
REQ-019 rst sampled on rising clk; while high, all outputs 0 except cmd_ready=0, state to IDLE, counters and err clear.
REQ-020 Reset mid-pulse truncates the pulse at that edge; no done is issued.
REQ-021 cmd_ready=1 on the first cycle after rst deasserts.

Structure
REQ-022 Shared package rram_pkg: op encodings, state enum, ADDR_W=12, LEN_W=8, default timing constants.
REQ-023 One sub-module, rram_phase_timer: loadable down-counter, asserts expiry on final cycle, used by SETUP/WPULSE/RECOV/SENSE.

Verification
REQ-024 READ addr 0x002, len 0, sense_in=1 -> dec_ale at cycle 1 with dec_addr=0x002, rd_valid+rd_data=1 at cycle 6, done at 7.
REQ-025 SET addr 0x010, len 2, sense_in=1 -> 3 pulses of 4 cycles; 2 dec_en strobes; addresses 0x010-0x012; err=0.
REQ-026 RESET addr 0x100, sense_in stuck 1 -> 4 wl_reset pulses; err=1; fail_addr=0x100; done issued.
REQ-027 READ addr 0xFFF, len 1 -> second cell dec_addr=0x000 after dec_en.
REQ-028 rst asserted during WPULSE of a SET -> wl_set low next edge; busy=0; no done; cmd_ready=1 after rst low.
REQ-029 op 11 -> err=1 and done one cycle after LATCH-free acceptance; no wl/sa activity; cmd_valid held during busy not re-accepted.
